irq_pending_ctrl: RTL

IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

---
 rtl/irq_pending_ctrl_pkg.sv | 17 +
 rtl/irq_pending_ctrl_sync.sv | 17 +
 rtl/irq_pending_ctrl.sv | 79 +++++++
 3 files changed

// File: rtl/irq_pending_ctrl_pkg.sv
// Shared constants, FSM encoding and the fixed-priority select used by irq_pending_ctrl.
package irq_pending_ctrl_pkg;
  localparam int NUM_LINES = 8;
  localparam int VEC_W     = 3;

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

  // Priority 1 > 2 > ... > 7 > 0: scan high to low so the lowest non-zero index wins,
  // falling back to 0 only when lines 1..7 are all clear.
  function automatic logic [VEC_W-1:0] prio_sel(input logic [NUM_LINES-1:0] p);
    logic [VEC_W-1:0] sel;
    sel = '0;
    for (int i = NUM_LINES - 1; i >= 1; i--)
      if (p[i]) sel = VEC_W'(i);
    return sel;
  endfunction
endpackage

// File: rtl/irq_pending_ctrl_sync.sv
// Multi-flop synchronizer for one asynchronous request line.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};

  assign q = ff[STAGES-1];
endmodule

// File: rtl/irq_pending_ctrl.sv
// Latches rising edges on async request lines as pending events and serves them one at a
// time by priority through an irq/vec/ack handshake.
module irq_pending_ctrl
  import irq_pending_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LINES-1:0] req_in,
  input  logic [NUM_LINES-1:0] mask,
  input  logic                 ack,
  output logic [NUM_LINES-1:0] pend,
  output logic                 irq,
  output logic [VEC_W-1:0]     vec
);
  logic [NUM_LINES-1:0] sync, hist, rise_q, pending, pending_nxt, clr, elig;
  state_t               state, state_nxt;
  logic                 irq_q, irq_nxt;
  logic [VEC_W-1:0]     vec_q, vec_nxt;

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_sync
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (req_in[i]),
      .q     (sync[i])
    );
  end

  assign elig = pending & ~mask;

  always_comb begin
    state_nxt = state;
    irq_nxt   = irq_q;
    vec_nxt   = vec_q;
    clr       = '0;
    case (state)
      IDLE: if (|elig) begin
        vec_nxt   = prio_sel(elig);
        irq_nxt   = 1'b1;
        state_nxt = SERVE;
      end
      // mask is deliberately ignored here so a service in flight always completes
      SERVE: if (ack) begin
        clr[vec_q] = 1'b1;
        irq_nxt    = 1'b0;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A fresh edge on the line being acked re-arms it: set wins over clear.
  assign pending_nxt = (pending & ~clr) | rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist    <= '0;
      rise_q  <= '0;
      pending <= '0;
      pend    <= '0;
      state   <= IDLE;
      irq_q   <= 1'b0;
      vec_q   <= '0;
    end else begin
      hist    <= sync;
      rise_q  <= sync & ~hist;
      pending <= pending_nxt;
      pend    <= elig;
      state   <= state_nxt;
      irq_q   <= irq_nxt;
      vec_q   <= vec_nxt;
    end
  end

  assign irq = irq_q;
  assign vec = vec_q;
endmodule
